// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing one result path among eight requesters,
// with a single-entry output register presented through a valid/ready handshake.
module result_bus_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [7:0]         Req,
  input  logic [8*WIDTH-1:0] InData,
  output logic [7:0]         Grant,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   OutData,
  output logic [2:0]         OutSrc,
  output logic [CNT_W-1:0]   TxCount
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic       load;
  logic       xfer;

  // Scan from ptr+7 down to ptr so the lane closest to ptr is the last writer.
  always_comb begin
    winner = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (Req[ptr + 3'(k)]) winner = ptr + 3'(k);
    end
  end

  assign xfer = (state == FULL) && OutReady && !Rst;
  assign load = (|Req) && ((state == EMPTY) || OutReady) && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (load) next_state = FULL;
      FULL:  if (!load && OutReady) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    OutValid = (state == FULL);
    Grant    = '0;
    if (load) Grant = 8'(1) << winner;
  end

  // Output register, round-robin pointer and transfer counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr     <= '0;
      OutData <= '0;
      OutSrc  <= '0;
      TxCount <= '0;
    end else begin
      if (xfer) TxCount <= TxCount + 1'b1;
      if (load) begin
        OutData <= InData[32'(winner)*WIDTH +: WIDTH];
        OutSrc  <= winner;
        ptr     <= winner + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Randomized and directed bench for result_bus_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_result_bus_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic               Clk = 1'b0;
  logic               Rst;
  logic [7:0]         Req;
  logic [8*WIDTH-1:0] InData;
  logic [7:0]         Grant;
  logic               OutValid;
  logic               OutReady;
  logic [WIDTH-1:0]   OutData;
  logic [2:0]         OutSrc;
  logic [CNT_W-1:0]   TxCount;

  result_bus_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .InData(InData), .Grant(Grant),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutSrc(OutSrc), .TxCount(TxCount)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit        m_valid;
  logic [31:0] m_data;
  int        m_src;
  int        m_ptr;
  int        m_cnt;
  logic [31:0] lane [8];

  // Values observed in the most recent step
  logic [7:0]  obs_grant;
  logic [31:0] obs_data;
  logic [2:0]  obs_src;
  logic [15:0] obs_tx;
  logic        obs_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] req, input logic rdy, input bit chk);
    bit   ld;
    int   w;
    logic [7:0] eg;
    @(negedge Clk);
    Rst = rst;
    Req = req;
    OutReady = rdy;
    for (int i = 0; i < 8; i++) InData[i*WIDTH +: WIDTH] = lane[i];
    #1;
    w = -1;
    for (int k = 0; k < 8; k++) begin
      if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
    end
    ld = !rst && (w >= 0) && (!m_valid || rdy);
    eg = ld ? 8'(1 << w) : 8'h00;
    obs_grant = Grant;
    obs_data  = OutData;
    obs_src   = OutSrc;
    obs_tx    = TxCount;
    obs_valid = OutValid;
    if (chk) begin
      check("grant", {56'd0, Grant}, {56'd0, eg});
      check("out_valid", {63'd0, OutValid}, {63'd0, m_valid});
      check("out_data", {32'd0, OutData}, {32'd0, m_data});
      check("out_src", {61'd0, OutSrc}, 64'(m_src));
      check("tx_count", {48'd0, TxCount}, 64'(m_cnt));
    end
    @(posedge Clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_valid && rdy) m_cnt = (m_cnt + 1) % 65536;
      if (ld) begin
        m_data = lane[w]; m_src = w; m_valid = 1; m_ptr = (w + 1) % 8;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    Rst = 1'b1; Req = '0; OutReady = 1'b0; InData = '0;
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) lane[i] = 32'h1000_0000 + 32'(i);

    // All lanes requesting through reset, then full rotation
    step(1, 8'hFF, 1, 1);
    check("t1_rst_grant", {56'd0, obs_grant}, 64'h0);
    step(1, 8'hFF, 1, 1);
    check("t1_rst_valid", {63'd0, obs_valid}, 64'h0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'hFF, 1, 1);
      check("t1_rr_grant", {56'd0, obs_grant}, 64'(1 << (i % 8)));
    end
    step(0, 8'h00, 1, 1);
    check("t1_tx8", {48'd0, obs_tx}, 64'd8);

    // Backpressure
    step(1, 8'h00, 0, 1);
    lane[3] = 32'hDEADBEEF;
    lane[5] = 32'h12345678;
    step(0, 8'h08, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h20, 0, 1);
      check("t2_hold_grant", {56'd0, obs_grant}, 64'h0);
      check("t2_hold_data", {32'd0, obs_data}, 64'hDEADBEEF);
      check("t2_hold_src", {61'd0, obs_src}, 64'd3);
    end
    step(0, 8'h20, 1, 1);
    check("t2_grant5", {56'd0, obs_grant}, 64'h20);
    step(0, 8'h00, 1, 1);
    check("t2_data5", {32'd0, obs_data}, 64'h12345678);
    check("t2_src5", {61'd0, obs_src}, 64'd5);

    // Wrap-around from ptr 7
    step(1, 8'h00, 1, 1);
    step(0, 8'h40, 1, 1);
    step(0, 8'h81, 1, 1);
    check("t3_grant7", {56'd0, obs_grant}, 64'h80);
    step(0, 8'h81, 1, 1);
    check("t3_grant0", {56'd0, obs_grant}, 64'h01);

    // Single lane streaming
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h04, 1, 1);
      check("t4_grant", {56'd0, obs_grant}, 64'h04);
    end
    check("t4_valid", {63'd0, obs_valid}, 64'h1);

    // Reset mid-handshake
    step(0, 8'h10, 0, 1);
    step(0, 8'h00, 0, 1);
    step(1, 8'h00, 0, 1);
    step(0, 8'h05, 1, 1);
    check("t5_valid", {63'd0, obs_valid}, 64'h0);
    check("t5_src", {61'd0, obs_src}, 64'd0);
    check("t5_grant", {56'd0, obs_grant}, 64'h01);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      for (int j = 0; j < 8; j++) lane[j] = $urandom;
      r = 8'($urandom) & 8'($urandom | ($urandom_range(0, 3) == 0 ? 0 : 32'hFF));
      step(($urandom_range(0, 99) == 0), r, 1'($urandom_range(0, 3) != 0), 1);
    end

    // Counter wrap
    step(1, 8'h00, 1, 1);
    step(0, 8'h04, 1, 1);
    for (int i = 0; i < 65535; i++) step(0, 8'h04, 1, 0);
    step(0, 8'h04, 1, 1);
    check("t6_ffff", {48'd0, obs_tx}, 64'hFFFF);
    step(0, 8'h00, 1, 1);
    check("t6_wrap", {48'd0, obs_tx}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
